row_assembler: RTL and testbench
================================

Name: row_assembler

Overview:
- Sits directly downstream of the JTAG USER-register deserializer, in the same tck domain.
- Consumes one ASCII byte per valid pulse and classifies each byte as a grid cell ('@' = occupied, '.' = empty), a row terminator, or end-of-input.
- Packs cells into fixed-width row bitmaps and emits one row per pulse for the grid-processing stages further on.
- Checks that all rows have a consistent width and reports errors as sticky flags.

Parameters:
- MAX_COLS, 160, maximum cells per row; width of the row bitmap.
- COL_WIDTH, $clog2(MAX_COLS+1), width of column and row-width counters.
- ROW_CNT_WIDTH, 16, width of the emitted-row counter.

Ports:
- tck  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- data  input  8  byte from the upstream deserializer, sampled only when valid=1.
- valid  input  1  single-cycle byte strobe.
- row_bits  output  MAX_COLS  emitted row; bit i = column i (leftmost char = bit 0); bits >= row_width are 0.
- row_width  output  COL_WIDTH  number of cells in the emitted row.
- row_valid  output  1  one-cycle pulse; row_bits and row_width are stable from this cycle until the next pulse.
- row_count  output  ROW_CNT_WIDTH  rows emitted so far.
- grid_done  output  1  one-cycle pulse after end-of-input is processed.
- err_width  output  1  sticky; a row length differed from the first row's length.
- err_overflow  output  1  sticky; more than MAX_COLS cells were received in one row.

Behaviour:
- Reset: rst_n=0 asynchronously clears all state and outputs to 0, and sets state to FIRST.
- Byte classes:
  - 0x40 '@': cell with value 1.
  - 0x2E '.': cell with value 0.
  - 0x0A: end of row (EOL).
  - 0x00: end of input (EOI).
  - Any other byte (including 0x0D): ignored; no state change.
- The work register and column counter col update on the same tck edge that samples valid=1.
- Cell with col < MAX_COLS: write work[col] = value, then col += 1.
- Cell with col == MAX_COLS: drop the cell and set err_overflow; col holds.
- EOL with col == 0: ignored (blank lines are tolerated).
- EOL with col > 0, on the sampling edge:
  - row_bits <= work; row_width <= col; clear work and col.
  - row_count += 1, saturating at all-ones.
  - row_valid = 1 in the following cycle, i.e. 1-cycle latency from the EOL sample.
- States:
  - FIRST: the first EOL with col > 0 latches ref_width = col, then goes to ROWS.
  - ROWS: each EOL with col > 0 and col != ref_width sets err_width. The row is still emitted.
  - DONE: all bytes are ignored; outputs hold; row_valid and grid_done stay 0. Exit only through rst_n.
- EOI in FIRST or ROWS:
  - If col > 0, flush the partial row exactly as an EOL would, including the width check. row_valid and grid_done then pulse in the same cycle.
  - Else grid_done pulses alone.
  - Next state is DONE.
- Back-to-back valid on consecutive cycles is supported at full rate. There is no backpressure, and the block never stalls.
- Reset mid-row discards the partial row and clears ref_width and the error flags.

Decomposition:
- Package row_assembler_pkg holds:
  - byte constants CHAR_ROLL=8'h40, CHAR_EMPTY=8'h2E, CHAR_EOL=8'h0A, CHAR_EOI=8'h00;
  - the state enum {FIRST, ROWS, DONE};
  - the byte-class enum {CELL1, CELL0, EOL, EOI, OTHER}.
- No sub-module: classification is a single combinational function in the package; the block itself stays flat.

Test Plan (MAX_COLS=8):
- "@.@\n" then 0x00 → one row_valid with row_bits=8'b0000_0101, row_width=3, row_count=1; grid_done one cycle later; no errors.
- "@@.\n.@@\n..@\n" back-to-back at one byte per cycle → three pulses with row_bits 0x03, 0x06, 0x04, all width 3; row_count=3.
- "@@@\n@@\n" → second row emitted with width 2 and row_bits=0x03; err_width=1 and stays set after further valid rows.
- Nine '@' then "\n" → err_overflow=1; row emitted with row_bits=0xFF, width 8.
- "@.\r\n\n.@" then 0x00 → the 0x0D byte and blank line are ignored; row_bits 0x01 then 0x02 are emitted. The second row_valid and grid_done are in the same cycle. After that, "@\n" produces no pulse (DONE state).
- rst_n=0 asynchronously after "@@" mid-row, then released, then ".@\n" → row_bits=0x02, width 2, row_count=1; err flags 0.

Source files
------------

// File: rtl/row_assembler_pkg.sv
// rtl/row_assembler_pkg.sv - byte constants, state/class enums and the byte classifier
package row_assembler_pkg;

  localparam logic [7:0] CHAR_ROLL  = 8'h40;
  localparam logic [7:0] CHAR_EMPTY = 8'h2E;
  localparam logic [7:0] CHAR_EOL   = 8'h0A;
  localparam logic [7:0] CHAR_EOI   = 8'h00;

  typedef enum logic [1:0] {FIRST, ROWS, DONE} state_e;

  typedef enum logic [2:0] {CELL1, CELL0, EOL, EOI, OTHER} byte_class_e;

  function automatic byte_class_e classify(input logic [7:0] b);
    case (b)
      CHAR_ROLL:  return CELL1;
      CHAR_EMPTY: return CELL0;
      CHAR_EOL:   return EOL;
      CHAR_EOI:   return EOI;
      default:    return OTHER;
    endcase
  endfunction

endpackage

// File: rtl/row_assembler.sv
// rtl/row_assembler.sv - packs ASCII grid bytes into row bitmaps with width/overflow checking
module row_assembler
  import row_assembler_pkg::*;
#(
  parameter int MAX_COLS      = 160,
  parameter int COL_WIDTH     = $clog2(MAX_COLS + 1),
  parameter int ROW_CNT_WIDTH = 16
) (
  input  logic                     tck,
  input  logic                     rst_n,
  input  logic [7:0]               data,
  input  logic                     valid,
  output logic [MAX_COLS-1:0]      row_bits,
  output logic [COL_WIDTH-1:0]     row_width,
  output logic                     row_valid,
  output logic [ROW_CNT_WIDTH-1:0] row_count,
  output logic                     grid_done,
  output logic                     err_width,
  output logic                     err_overflow
);

  localparam logic [COL_WIDTH-1:0] COL_FULL = COL_WIDTH'(MAX_COLS);

  state_e                state;
  logic [MAX_COLS-1:0]   work;
  logic [COL_WIDTH-1:0]  col;
  logic [COL_WIDTH-1:0]  ref_width;

  byte_class_e cls;
  logic        active;
  logic        is_cell;
  logic        is_eol;
  logic        is_eoi;
  logic        flush;

  always_comb begin
    cls     = classify(data);
    active  = valid && (state != DONE);
    is_cell = active && ((cls == CELL1) || (cls == CELL0));
    is_eol  = active && (cls == EOL);
    is_eoi  = active && (cls == EOI);
    // Blank lines never emit; EOI flushes a partial row just like EOL.
    flush   = (is_eol || is_eoi) && (col != '0);
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FIRST;
      work         <= '0;
      col          <= '0;
      ref_width    <= '0;
      row_bits     <= '0;
      row_width    <= '0;
      row_valid    <= 1'b0;
      row_count    <= '0;
      grid_done    <= 1'b0;
      err_width    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      row_valid <= 1'b0;
      grid_done <= 1'b0;

      if (is_cell) begin
        if (col != COL_FULL) begin
          // work is cleared on every flush, so only the set case needs writing.
          work <= work | (MAX_COLS'(cls == CELL1) << col);
          col  <= col + 1'b1;
        end else begin
          err_overflow <= 1'b1;
        end
      end

      if (flush) begin
        row_bits  <= work;
        row_width <= col;
        row_valid <= 1'b1;
        work      <= '0;
        col       <= '0;
        if (row_count != '1) row_count <= row_count + 1'b1;
        if (state == FIRST) begin
          ref_width <= col;
          state     <= ROWS;
        end else if (col != ref_width) begin
          err_width <= 1'b1;
        end
      end

      if (is_eoi) begin
        grid_done <= 1'b1;
        state     <= DONE;
      end
    end
  end

endmodule

// File: tb/tb_row_assembler.sv
// tb/tb_row_assembler.sv - table-driven and randomized checks of row_assembler
module tb_row_assembler;

  localparam int MC      = 8;
  localparam int CW      = $clog2(MC + 1);
  localparam int RCW     = 4;
  localparam int CNT_MAX = (1 << RCW) - 1;

  logic           tck;
  logic           rst_n;
  logic [7:0]     data;
  logic           valid;
  logic [MC-1:0]  row_bits;
  logic [CW-1:0]  row_width;
  logic           row_valid;
  logic [RCW-1:0] row_count;
  logic           grid_done;
  logic           err_width;
  logic           err_overflow;

  row_assembler #(.MAX_COLS(MC), .ROW_CNT_WIDTH(RCW)) dut (
    .tck(tck), .rst_n(rst_n), .data(data), .valid(valid),
    .row_bits(row_bits), .row_width(row_width), .row_valid(row_valid),
    .row_count(row_count), .grid_done(grid_done),
    .err_width(err_width), .err_overflow(err_overflow)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit rv, input logic [7:0] b, input int w,
                         input int c, input bit gd, input bit ew, input bit eo);
    chk({tag, ".row_valid"}, 32'(row_valid), 32'(rv));
    chk({tag, ".row_bits"}, 32'(row_bits), 32'(b));
    chk({tag, ".row_width"}, 32'(row_width), 32'(w));
    chk({tag, ".row_count"}, 32'(row_count), 32'(c));
    chk({tag, ".grid_done"}, 32'(grid_done), 32'(gd));
    chk({tag, ".err_width"}, 32'(err_width), 32'(ew));
    chk({tag, ".err_overflow"}, 32'(err_overflow), 32'(eo));
  endtask

  // Drive one byte; returns at the negedge after the sampling edge.
  task automatic send(input bit v, input logic [7:0] d);
    data  = d;
    valid = v;
    @(negedge tck);
    valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(1'b1, s[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge tck);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    bit         vld;
    logic [7:0] d;
    bit         rv;
    logic [7:0] bits;
    int         w;
    int         cnt;
    bit         gd;
    bit         ew;
    bit         eo;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input logic [7:0] d, input bit rv, input logic [7:0] b,
                     input int w, input int c, input bit gd, input bit ew, input bit eo);
    vec_t v;
    v = '{rst: r, vld: 1'b1, d: d, rv: rv, bits: b, w: w, cnt: c, gd: gd, ew: ew, eo: eo};
    tbl.push_back(v);
  endtask

  // Bytes that must not produce any pulse: outputs hold at the previous entry's values.
  task automatic quiet(input string s);
    vec_t v;
    for (int i = 0; i < s.len(); i++) begin
      v     = tbl[$];
      v.rst = 1'b0; v.vld = 1'b1; v.d = s[i]; v.rv = 1'b0; v.gd = 1'b0;
      tbl.push_back(v);
    end
  endtask

  task automatic idle();
    vec_t v;
    v     = tbl[$];
    v.rst = 1'b0; v.vld = 1'b0; v.d = 8'h40; v.rv = 1'b0; v.gd = 1'b0;
    tbl.push_back(v);
  endtask

  // Reference model: a row is a queue of cell values; outputs derived from grid rules.
  bit         m_row[$];
  int         m_ref;
  bit         m_done;
  bit         m_rv, m_gd, m_ew, m_eo;
  logic [7:0] m_bits;
  int         m_w, m_cnt;

  task automatic model_reset();
    m_row.delete();
    m_ref = -1; m_done = 0;
    m_rv = 0; m_gd = 0; m_ew = 0; m_eo = 0; m_bits = 0; m_w = 0; m_cnt = 0;
  endtask

  task automatic model_flush();
    m_bits = '0;
    foreach (m_row[i]) if (m_row[i]) m_bits = m_bits + (8'd1 << i);
    m_w = m_row.size();
    if (m_ref < 0) m_ref = m_w;
    else if (m_w != m_ref) m_ew = 1;
    m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    m_rv  = 1;
    m_row.delete();
  endtask

  task automatic model_step(input bit v, input logic [7:0] d);
    m_rv = 0; m_gd = 0;
    if (v && !m_done) begin
      if (d == 8'h40 || d == 8'h2E) begin
        if (m_row.size() < MC) m_row.push_back(d == 8'h40);
        else m_eo = 1;
      end else if (d == 8'h0A) begin
        if (m_row.size() > 0) model_flush();
      end else if (d == 8'h00) begin
        if (m_row.size() > 0) model_flush();
        m_gd = 1; m_done = 1;
      end
    end
  endtask

  initial begin
    logic [7:0] b;
    int         r;
    bit         v;

    rst_n = 1'b0; data = 8'h00; valid = 1'b0;
    repeat (2) @(negedge tck);
    chk_all("reset", 0, 8'h00, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Single row then EOI on the next cycle
    add(1, "@", 0, 8'h00, 0, 0, 0, 0, 0); quiet(".@");
    add(0, 8'h0A, 1, 8'h05, 3, 1, 0, 0, 0);
    add(0, 8'h00, 0, 8'h05, 3, 1, 1, 0, 0);
    idle();
    // Three rows back to back
    add(1, "@", 0, 8'h00, 0, 0, 0, 0, 0); quiet("@.");
    add(0, 8'h0A, 1, 8'h03, 3, 1, 0, 0, 0); quiet(".@@");
    add(0, 8'h0A, 1, 8'h06, 3, 2, 0, 0, 0); quiet("..@");
    add(0, 8'h0A, 1, 8'h04, 3, 3, 0, 0, 0);
    // Width mismatch stays sticky across later good rows
    add(1, "@", 0, 8'h00, 0, 0, 0, 0, 0); quiet("@@");
    add(0, 8'h0A, 1, 8'h07, 3, 1, 0, 0, 0); quiet("@@");
    add(0, 8'h0A, 1, 8'h03, 2, 2, 0, 1, 0); quiet(".@.");
    add(0, 8'h0A, 1, 8'h02, 3, 3, 0, 1, 0);
    // Ninth cell overflows and is dropped
    add(1, "@", 0, 8'h00, 0, 0, 0, 0, 0); quiet("@@@@@@@");
    add(0, "@", 0, 8'h00, 0, 0, 0, 0, 1);
    add(0, 8'h0A, 1, 8'hFF, 8, 1, 0, 0, 1);
    // CR and blank line ignored; EOI flush pulses with grid_done; DONE ignores input
    add(1, "@", 0, 8'h00, 0, 0, 0, 0, 0); quiet(".\015");
    add(0, 8'h0A, 1, 8'h01, 2, 1, 0, 0, 0); quiet("\n.@");
    add(0, 8'h00, 1, 8'h02, 2, 2, 1, 0, 0); quiet("@\n");
    idle();
    // EOI with nothing pending
    add(1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0);
    idle(); quiet("@\n");

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      send(tbl[i].vld, tbl[i].d);
      chk_all($sformatf("vec%0d", i), tbl[i].rv, tbl[i].bits, tbl[i].w, tbl[i].cnt,
              tbl[i].gd, tbl[i].ew, tbl[i].eo);
    end

    // Asynchronous reset mid-row, between clock edges
    do_reset();
    send_str("@@@\n@\n@@");
    chk("pre_async.err_width", 32'(err_width), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 8'h00, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    @(negedge tck);
    send_str(".@\n");
    chk_all("after_async", 1, 8'h02, 2, 1, 0, 0, 0);

    // Randomized rounds against the reference model
    for (int round = 0; round < 4; round++) begin
      do_reset();
      model_reset();
      for (int i = 0; i < 250; i++) begin
        v = ($urandom_range(0, 9) != 0);
        r = $urandom_range(0, 99);
        if (r < 34)      b = 8'h40;
        else if (r < 68) b = 8'h2E;
        else if (r < 86) b = 8'h0A;
        else if (r < 93) b = 8'h0D;
        else if (r < 96) b = 8'h41;
        else             b = (i < 150) ? 8'h0A : 8'h00;
        send(v, b);
        model_step(v, b);
        chk_all($sformatf("rnd%0d.%0d", round, i), m_rv, m_bits, m_w, m_cnt, m_gd, m_ew, m_eo);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
